// File: rtl/lcd_arb_pkg.sv
// Shared state encoding and width constants for the LCD request arbiter.
package lcd_arb_pkg;

  localparam int unsigned CRTL_W_DEF = 31;
  localparam int unsigned TIMEOUT_W  = 16;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_ARB       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr (with wrap) wins.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan ptr+1 .. ptr+N_REQ so the last winner has the lowest priority.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_idx      = cand;
        win[cand]    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/lcd_req_arbiter.sv
// Round-robin arbiter sharing one LCD controller between N_REQ requesters.
// Optional WAIT_DONE watchdog is built when LCD_ARB_TIMEOUT_EN is defined.
module lcd_req_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned CRTL_W      = CRTL_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*CRTL_W-1:0] req_word,
  input  logic                    ini_finish,
  input  logic                    run_finish,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    lcdcrtl_en,
  output logic [CRTL_W-1:0]       lcd_crtl,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned      IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  grant_d, done_d, win;
  logic [IDX_W-1:0]  win_idx;
  logic              any, en_d, err_d, cap_en, wdog_expired;
  logic [CRTL_W-1:0] words [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
    assign words[gi] = req_word[gi*CRTL_W +: CRTL_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

`ifdef LCD_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  // Cleared while issuing so it reads 0 in the first WAIT_DONE cycle.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_ISSUE) begin
      wdog_d = '0;
    end else if (state_q == ST_WAIT_DONE) begin
      wdog_d = wdog_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign wdog_expired = (state_q == ST_WAIT_DONE) && (wdog_q == WDOG_LAST);
`else
  assign wdog_expired = 1'b0;

  // No watchdog in this build; TIMEOUT_CYC only keeps the parameter list uniform.
  if (TIMEOUT_CYC == 0) begin : g_no_wdog
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    done_d  = '0;
    en_d    = 1'b0;
    err_d   = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (ini_finish) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (any) begin
          grant_d = win;
          ptr_d   = win_idx;
          cap_en  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        en_d    = 1'b1;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (run_finish) begin
          done_d[ptr_q] = 1'b1;
          state_d       = ST_GAP;
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_ARB;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Registered outputs; the word is captured only on a grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant      <= '0;
      done       <= '0;
      lcdcrtl_en <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b1;
      lcd_crtl   <= '0;
    end else begin
      grant      <= grant_d;
      done       <= done_d;
      lcdcrtl_en <= en_d;
      err        <= err_d;
      busy       <= (state_d != ST_ARB);
      if (cap_en) lcd_crtl <= words[win_idx];
    end
  end

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Self-checking bench for lcd_req_arbiter: vector table plus grant scoreboard.
module tb_lcd_req_arbiter;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned CRTL_W = 31;
`ifdef LCD_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 4096;
`endif

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*CRTL_W-1:0] req_word;
  logic                    ini_finish;
  logic                    run_finish;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    lcdcrtl_en;
  logic [CRTL_W-1:0]       lcd_crtl;
  logic                    busy;
  logic                    err;

  logic [CRTL_W-1:0] w [N_REQ];
  assign req_word = {w[3], w[2], w[1], w[0]};

  always #5 clk = ~clk;

  lcd_req_arbiter #(
    .N_REQ       (N_REQ),
    .CRTL_W      (CRTL_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .req_word   (req_word),
    .ini_finish (ini_finish),
    .run_finish (run_finish),
    .grant      (grant),
    .done       (done),
    .lcdcrtl_en (lcdcrtl_en),
    .lcd_crtl   (lcd_crtl),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic [N_REQ-1:0]  grant;
    logic [CRTL_W-1:0] word;
  } sb_t;

  typedef struct {
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] exp_grant;
    int               run_dly;
  } vec_t;

  sb_t               sb_q [$];
  vec_t              tbl [11];
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [N_REQ-1:0]  cur_grant;
  logic [CRTL_W-1:0] cur_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N_REQ-1:0] oh);
    for (int i = 0; i < N_REQ; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Fresh random words, raise req, and record the expected winner and its word.
  task automatic drive(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] exp_g);
    sb_t e;
    for (int i = 0; i < N_REQ; i++) w[i] = CRTL_W'($urandom);
    req     = r;
    e.grant = exp_g;
    e.word  = w[oh2idx(exp_g)];
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for a grant, compare against the scoreboard, then check the start pulse.
  task automatic take_grant(input string tag, output int cycles);
    sb_t e;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (grant == '0 && cycles < 40);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got grant 0x%0h, want none", tag, grant);
      return;
    end
    e = sb_q.pop_front();
    check({tag, " grant"}, 32'(grant), 32'(e.grant));
    cur_grant = e.grant;
    cur_word  = e.word;
    @(negedge clk);
    check({tag, " en"}, 32'(lcdcrtl_en), 32'd1);
    check({tag, " word"}, 32'(lcd_crtl), 32'(e.word));
    for (int i = 0; i < N_REQ; i++) w[i] = ~w[i];
  endtask

  // Pulse run_finish after dly cycles and expect done next cycle, word held, no stray pulses.
  task automatic finish_run(input string tag, input int dly);
    int stray;
    stray = 0;
    repeat (dly) begin
      @(negedge clk);
      if (lcdcrtl_en || grant != '0 || done != '0) stray++;
    end
    run_finish = 1'b1;
    @(negedge clk);
    run_finish = 1'b0;
    check({tag, " done"}, 32'(done), 32'(cur_grant));
    check({tag, " held"}, 32'(lcd_crtl), 32'(cur_word));
    check({tag, " stray"}, 32'(stray), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int act;

    tbl = '{
      '{4'b1111, 4'b0001, 2}, '{4'b1111, 4'b0010, 0}, '{4'b1111, 4'b0100, 1},
      '{4'b1111, 4'b1000, 3}, '{4'b1111, 4'b0001, 5}, '{4'b1010, 4'b0010, 1},
      '{4'b1010, 4'b1000, 2}, '{4'b0001, 4'b0001, 0}, '{4'b0110, 4'b0010, 4},
      '{4'b1001, 4'b1000, 1}, '{4'b1001, 4'b0001, 2}
    };

    rstn       = 1'b0;
    req        = '0;
    ini_finish = 1'b0;
    run_finish = 1'b0;
    for (int i = 0; i < N_REQ; i++) w[i] = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd1);
    check("rst grant", 32'(grant), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst en", 32'(lcdcrtl_en), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst word", 32'(lcd_crtl), 32'd0);
    rstn = 1'b1;

    // Requests are ignored until the panel init completes.
    drive(4'b0001, 4'b0001);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant != '0 || lcdcrtl_en) act++;
    end
    check("init hold", 32'(act), 32'd0);
    ini_finish = 1'b1;
    take_grant("t1", lat);
    check("t1 latency", 32'(lat), 32'd2);
    finish_run("t1", 3);

    // Single requester with a known word and a long transfer.
    begin
      sb_t e;
      for (int i = 0; i < N_REQ; i++) w[i] = CRTL_W'($urandom);
      w[2]    = 31'h1234567;
      req     = 4'b0100;
      e.grant = 4'b0100;
      e.word  = 31'h1234567;
      sb_q.push_back(e);
    end
    take_grant("t2", lat);
    check("t2 latency", 32'(lat), 32'd2);
    check("t2 busy", 32'(busy), 32'd1);
    finish_run("t2", 10);

    // Async reset while the start pulse is high.
    drive(4'b0010, 4'b0010);
    take_grant("t5", lat);
    #2 rstn = 1'b0;
    #1;
    check("t5 en drop", 32'(lcdcrtl_en), 32'd0);
    check("t5 busy", 32'(busy), 32'd1);
    check("t5 word clr", 32'(lcd_crtl), 32'd0);
    run_finish = 1'b1;
    @(negedge clk);
    run_finish = 1'b0;
    check("t5 no done", 32'(done), 32'd0);
    @(negedge clk);

    // Round-robin vectors; the first one is released from reset with ptr at N_REQ-1.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].req, tbl[i].exp_grant);
      if (i == 0) rstn = 1'b1;
      if (i == 1) ini_finish = 1'b0;
      take_grant($sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      finish_run($sformatf("vec%0d", i), tbl[i].run_dly);
    end

    // Idle: run_finish outside WAIT_DONE must be ignored.
    req = '0;
    repeat (4) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    run_finish = 1'b1;
    @(negedge clk);
    run_finish = 1'b0;
    check("idle done", 32'(done), 32'd0);
    @(negedge clk);
    check("idle done2", 32'(done), 32'd0);
    check("idle busy2", 32'(busy), 32'd0);
    check("idle en", 32'(lcdcrtl_en), 32'd0);

`ifdef LCD_ARB_TIMEOUT_EN
    // Watchdog expiry without run_finish, then run_finish on the expiry cycle.
    drive(4'b0100, 4'b0100);
    take_grant("to1", lat);
    act = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (done != '0) act++;
    end while (!err && lat < 40);
    check("to1 err cycles", 32'(lat), 32'd16);
    check("to1 no done", 32'(act), 32'd0);
    drive(4'b1000, 4'b1000);
    take_grant("to2", lat);
    check("to2 latency", 32'(lat), 32'd2);
    repeat (15) @(negedge clk);
    run_finish = 1'b1;
    @(negedge clk);
    run_finish = 1'b0;
    check("to2 done", 32'(done), 32'(4'b1000));
    check("to2 err", 32'(err), 32'd0);
    req = '0;
`endif

    if (sb_q.size() != 0) check("sb leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
